// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 read-cycle controller: FSM state encoding,
// wait-state limit and the device-select codes understood by the CPU
// data-input multiplexer.
package z80_bus_pkg;

    // Largest number of ROM wait states the counter can express.
    localparam int ROM_WAITS_MAX = 7;

    // Read-cycle controller states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ROM_WT   = 3'd1,
        ST_ROM_RD   = 3'd2,
        ST_IO_SETUP = 3'd3,
        ST_IO_WT    = 3'd4,
        ST_IO_RD    = 3'd5,
        ST_END      = 3'd6
    } rc_state_e;

    // Data-input mux source codes; at most one device is ever selected.
    typedef enum logic [1:0] {
        DEV_NONE   = 2'b00,
        DEV_ROM    = 2'b01,
        DEV_INPORT = 2'b10
    } dev_sel_e;

    // Which mux source a given controller state steers onto the CPU bus.
    function automatic dev_sel_e state_dev_sel(input rc_state_e st);
        dev_sel_e sel;
        case (st)
            ST_ROM_WT, ST_ROM_RD:             sel = DEV_ROM;
            ST_IO_SETUP, ST_IO_WT, ST_IO_RD:  sel = DEV_INPORT;
            default:                          sel = DEV_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/z80_read_ctrl_if.sv
// CPU-side and S-100-side signals of the read-cycle controller.
// master: the CPU / bus environment; slave: the controller itself.
interface z80_read_ctrl_if;
    logic [15:0] cpu_addr;
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic        cpu_rd_n;
    logic        cpu_m1_n;
    logic        s100_rdy;
    logic        rom_cs;
    logic        inport_cs;
    logic        cpu_wait_n;
    logic        s100_sinp;
    logic        s100_pdbin;
    logic        bus_err;

    modport master (
        output cpu_addr, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_m1_n, s100_rdy,
        input  rom_cs, inport_cs, cpu_wait_n, s100_sinp, s100_pdbin, bus_err
    );

    modport slave (
        input  cpu_addr, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_m1_n, s100_rdy,
        output rom_cs, inport_cs, cpu_wait_n, s100_sinp, s100_pdbin, bus_err
    );
endinterface

// File: rtl/z80rc_addr_dec.sv
// Combinational address decode: ROM window hit and S-100 port-range hit.
module z80rc_addr_dec #(
    parameter logic [15:0] ROM_BASE = 16'hF000,
    parameter int          ROM_AW   = 12,
    parameter logic [7:0]  PORT_LO  = 8'h00,
    parameter logic [7:0]  PORT_HI  = 8'hFF
) (
    input  logic [15:0] addr,
    output logic        rom_hit,
    output logic        port_hit
);

    localparam logic [15:0] ROM_TAG = ROM_BASE >> ROM_AW;

    logic [15:0] rom_tag_s;
    logic [8:0]  lo_diff_s;
    logic [8:0]  hi_diff_s;

    // Compare the address above the ROM window against the base, and the
    // port number against the inclusive range using borrow bits so that
    // full-range settings need no special casing.
    always_comb begin
        rom_tag_s = addr >> ROM_AW;
        rom_hit   = (rom_tag_s == ROM_TAG);
        lo_diff_s = {1'b0, addr[7:0]} - {1'b0, PORT_LO};
        hi_diff_s = {1'b0, PORT_HI} - {1'b0, addr[7:0]};
        port_hit  = ~lo_diff_s[8] & ~hi_diff_s[8];
    end

endmodule

// File: rtl/z80_read_ctrl.sv
// Z80 read-cycle controller: decodes CPU memory/IO reads, drives the one-hot
// data-input mux selects, inserts ROM wait states and runs the S-100
// sINP/pDBIN/RDY input handshake. All outputs are registered.
// Optional feature macro: Z80RC_TIMEOUT_EN (RDY timeout with bus_err pulse).
module z80_read_ctrl
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] ROM_BASE    = 16'hF000,
    parameter int          ROM_AW      = 12,
    parameter int          ROM_WAITS   = 1,
    parameter logic [7:0]  PORT_LO     = 8'h00,
    parameter logic [7:0]  PORT_HI     = 8'hFF,
    parameter int          RDY_TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset_n,
    z80_read_ctrl_if.slave  bus
);

    localparam int WAITS_EFF = (ROM_WAITS > ROM_WAITS_MAX) ? ROM_WAITS_MAX : ROM_WAITS;
    localparam logic [2:0] WAIT_LAST = (WAITS_EFF > 0) ? 3'(WAITS_EFF - 1) : 3'd0;

    rc_state_e  state_q, state_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic       rom_cs_q, rom_cs_d;
    logic       inport_cs_q, inport_cs_d;
    logic       wait_n_q, wait_n_d;
    logic       sinp_q, sinp_d;
    logic       pdbin_q, pdbin_d;
    logic       bus_err_q, bus_err_d;
    logic       rom_hit_s, port_hit_s;
    logic       mem_rd_s, io_rd_s;
    dev_sel_e   dev_sel_s;

`ifdef Z80RC_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = (RDY_TIMEOUT > 0) ? 8'(RDY_TIMEOUT - 1) : 8'd0;
    logic [7:0] to_cnt_q, to_cnt_d;
`endif

    z80rc_addr_dec #(
        .ROM_BASE (ROM_BASE),
        .ROM_AW   (ROM_AW),
        .PORT_LO  (PORT_LO),
        .PORT_HI  (PORT_HI)
    ) u_addr_dec (
        .addr     (bus.cpu_addr),
        .rom_hit  (rom_hit_s),
        .port_hit (port_hit_s)
    );

    // Next-state, wait/timeout counters, and output values for the next state.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        bus_err_d = 1'b0;
`ifdef Z80RC_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        // A read needs RD low and exactly one of MREQ/IORQ low.
        mem_rd_s = ~bus.cpu_rd_n & ~bus.cpu_mreq_n &  bus.cpu_iorq_n;
        io_rd_s  = ~bus.cpu_rd_n &  bus.cpu_mreq_n & ~bus.cpu_iorq_n;

        case (state_q)
            ST_IDLE: begin
                if (mem_rd_s && rom_hit_s) begin
                    state_d = (WAITS_EFF > 0) ? ST_ROM_WT : ST_ROM_RD;
                    wcnt_d  = 3'd0;
                end else if (io_rd_s && bus.cpu_m1_n && port_hit_s) begin
                    // M1 together with IORQ is an interrupt acknowledge.
                    state_d = ST_IO_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROM_WT: begin
                if (bus.cpu_rd_n) begin
                    state_d = ST_END;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_ROM_RD;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            ST_ROM_RD: begin
                if (bus.cpu_rd_n) begin
                    state_d = ST_END;
                end else begin
                    state_d = ST_ROM_RD;
                end
            end
            ST_IO_SETUP: begin
                if (bus.cpu_rd_n) begin
                    state_d = ST_END;
                end else begin
                    state_d = ST_IO_WT;
`ifdef Z80RC_TIMEOUT_EN
                    to_cnt_d = 8'd0;
`endif
                end
            end
            ST_IO_WT: begin
                if (bus.cpu_rd_n) begin
                    state_d = ST_END;
                end else if (bus.s100_rdy) begin
                    state_d = ST_IO_RD;
`ifdef Z80RC_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    // Give up on RDY: release the CPU with whatever is on the bus.
                    state_d   = ST_IO_RD;
                    bus_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`else
                end else begin
                    state_d = ST_IO_WT;
                end
`endif
            end
            ST_IO_RD: begin
                if (bus.cpu_rd_n) begin
                    state_d = ST_END;
                end else begin
                    state_d = ST_IO_RD;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are a pure function of the state being entered, so the
        // registered copies line up with the state register.
        dev_sel_s   = state_dev_sel(state_d);
        rom_cs_d    = (dev_sel_s == DEV_ROM);
        inport_cs_d = (dev_sel_s == DEV_INPORT);
        sinp_d      = (state_d == ST_IO_SETUP) || (state_d == ST_IO_WT) || (state_d == ST_IO_RD);
        pdbin_d     = (state_d == ST_IO_WT) || (state_d == ST_IO_RD);
        wait_n_d    = ~((state_d == ST_ROM_WT) || (state_d == ST_IO_SETUP) || (state_d == ST_IO_WT));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 3'd0;
            rom_cs_q    <= 1'b0;
            inport_cs_q <= 1'b0;
            wait_n_q    <= 1'b1;
            sinp_q      <= 1'b0;
            pdbin_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rom_cs_q    <= rom_cs_d;
            inport_cs_q <= inport_cs_d;
            wait_n_q    <= wait_n_d;
            sinp_q      <= sinp_d;
            pdbin_q     <= pdbin_d;
            bus_err_q   <= bus_err_d;
        end
    end

`ifdef Z80RC_TIMEOUT_EN
    // RDY timeout counter, cleared on entry to IO_WT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign bus.rom_cs     = rom_cs_q;
    assign bus.inport_cs  = inport_cs_q;
    assign bus.cpu_wait_n = wait_n_q;
    assign bus.s100_sinp  = sinp_q;
    assign bus.s100_pdbin = pdbin_q;
    assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_z80_read_ctrl.sv
// Directed bench for z80_read_ctrl with a scoreboard of expected results.
// Timeout scenario runs only when Z80RC_TIMEOUT_EN is defined.
module tb_z80_read_ctrl;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    z80_read_ctrl_if bus ();

    z80_read_ctrl #(
        .ROM_BASE    (16'hF000),
        .ROM_AW      (12),
        .ROM_WAITS   (1),
        .PORT_LO     (8'h00),
        .PORT_HI     (8'hF0),
        .RDY_TIMEOUT (10)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct { string tag; int val; } exp_t;
    exp_t exp_q[$];

    // Observations of the most recent read cycle.
    int o_rom, o_inp, o_sinp, o_wait, o_err, o_first_pd, o_gap, o_after, o_done;
    bit first_seen;

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag, input int obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val && tag == e.tag) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d (entry %s)", tag, obs, e.val, e.tag);
            end
        end
    endtask

    function automatic int pack_out();
        return {26'd0, bus.rom_cs, bus.inport_cs, bus.s100_sinp,
                bus.s100_pdbin, bus.bus_err, bus.cpu_wait_n};
    endfunction

    task automatic sample_obs();
        if (bus.rom_cs)     o_rom = 1;
        if (bus.inport_cs)  o_inp = 1;
        if (bus.s100_sinp)  o_sinp = 1;
        if (!bus.cpu_wait_n) o_wait++;
        if (bus.bus_err)    o_err++;
        if (bus.s100_sinp && !first_seen) begin
            first_seen = 1'b1;
            o_first_pd = int'(bus.s100_pdbin);
        end
        if (bus.s100_sinp && !bus.inport_cs) o_gap = 1;
    endtask

    task automatic drive_idle();
        bus.cpu_addr   = 16'h0000;
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_iorq_n = 1'b1;
        bus.cpu_rd_n   = 1'b1;
        bus.cpu_m1_n   = 1'b1;
        bus.s100_rdy   = 1'b0;
    endtask

    task automatic drive_read(input logic [15:0] a, input bit io, input bit m1n);
        bus.cpu_addr   = a;
        bus.cpu_m1_n   = m1n;
        bus.cpu_mreq_n = io;
        bus.cpu_iorq_n = ~io;
        bus.cpu_rd_n   = 1'b0;
    endtask

    // One full CPU read; rdy_dly = IO_WT clocks before RDY is offered (-1 never).
    task automatic run_read(input logic [15:0] a, input bit io, input bit m1n,
                            input int rdy_dly, input int budget);
        int pd_cnt;
        pd_cnt = 0;
        o_rom = 0; o_inp = 0; o_sinp = 0; o_wait = 0; o_err = 0;
        o_first_pd = -1; o_gap = 0; o_after = -1; o_done = 0;
        first_seen = 1'b0;
        @(negedge clock);
        drive_read(a, io, m1n);
        bus.s100_rdy = (rdy_dly == 0);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            sample_obs();
            if (bus.s100_pdbin) pd_cnt++;
            bus.s100_rdy = (rdy_dly >= 0) && (pd_cnt >= rdy_dly);
            if ((bus.rom_cs || bus.inport_cs) && bus.cpu_wait_n) begin
                o_done = 1;
                break;
            end
        end
        repeat (2) begin
            @(negedge clock);
            sample_obs();
        end
        drive_idle();
        @(negedge clock);
        o_after = int'(bus.rom_cs | bus.inport_cs | bus.s100_sinp | bus.s100_pdbin);
        if (bus.bus_err) o_err++;
        @(negedge clock);
    endtask

    // Mux selects must be one-hot and pDBIN must sit inside the port select.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            checks++;
            assert (!(bus.rom_cs && bus.inport_cs)) else begin
                errors++;
                $error("FAIL inv_onehot observed=%0b%0b expected=not 11", bus.rom_cs, bus.inport_cs);
            end
            checks++;
            assert (!bus.s100_pdbin || bus.inport_cs) else begin
                errors++;
                $error("FAIL inv_pdbin observed=pdbin1 inport%0b expected=inport1", bus.inport_cs);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        drive_idle();
        #12;
        push("reset_state", 1);
        pop_cmp("reset_state", pack_out());
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // ROM read at F123, one wait state.
        push("rom_cs", 1); push("rom_inp", 0); push("rom_wait", 1);
        push("rom_done", 1); push("rom_after", 0);
        run_read(16'hF123, 1'b0, 1'b1, -1, 20);
        pop_cmp("rom_cs", o_rom); pop_cmp("rom_inp", o_inp); pop_cmp("rom_wait", o_wait);
        pop_cmp("rom_done", o_done); pop_cmp("rom_after", o_after);

        // IO read of port 01, RDY after 5 IO_WT clocks.
        push("io5_inp", 1); push("io5_rom", 0); push("io5_first_pd", 0); push("io5_gap", 0);
        push("io5_wait", 6); push("io5_err", 0); push("io5_after", 0);
        run_read(16'h0001, 1'b1, 1'b1, 5, 20);
        pop_cmp("io5_inp", o_inp); pop_cmp("io5_rom", o_rom); pop_cmp("io5_first_pd", o_first_pd);
        pop_cmp("io5_gap", o_gap); pop_cmp("io5_wait", o_wait); pop_cmp("io5_err", o_err);
        pop_cmp("io5_after", o_after);

        // Memory read outside the ROM window.
        push("mem_rom", 0); push("mem_inp", 0); push("mem_wait", 0);
        run_read(16'h0100, 1'b0, 1'b1, -1, 6);
        pop_cmp("mem_rom", o_rom); pop_cmp("mem_inp", o_inp); pop_cmp("mem_wait", o_wait);

        // Interrupt acknowledge is not a port read.
        push("inta_inp", 0); push("inta_sinp", 0); push("inta_wait", 0);
        run_read(16'h0001, 1'b1, 1'b0, -1, 6);
        pop_cmp("inta_inp", o_inp); pop_cmp("inta_sinp", o_sinp); pop_cmp("inta_wait", o_wait);

        // RDY already high on entry still costs one IO_WT clock.
        push("io0_wait", 2); push("io0_inp", 1);
        run_read(16'h0001, 1'b1, 1'b1, 0, 20);
        pop_cmp("io0_wait", o_wait); pop_cmp("io0_inp", o_inp);

        // Port range boundaries: F0 routed, F1 not.
        push("pF0_inp", 1); push("pF0_wait", 2);
        run_read(16'h00F0, 1'b1, 1'b1, 1, 20);
        pop_cmp("pF0_inp", o_inp); pop_cmp("pF0_wait", o_wait);
        push("pF1_inp", 0); push("pF1_sinp", 0);
        run_read(16'h00F1, 1'b1, 1'b1, 1, 6);
        pop_cmp("pF1_inp", o_inp); pop_cmp("pF1_sinp", o_sinp);

        // ROM window boundaries.
        push("rF000_cs", 1); push("rF000_wait", 1);
        run_read(16'hF000, 1'b0, 1'b1, -1, 20);
        pop_cmp("rF000_cs", o_rom); pop_cmp("rF000_wait", o_wait);
        push("rFFFF_cs", 1);
        run_read(16'hFFFF, 1'b0, 1'b1, -1, 20);
        pop_cmp("rFFFF_cs", o_rom);
        push("rEFFF_cs", 0); push("rEFFF_wait", 0);
        run_read(16'hEFFF, 1'b0, 1'b1, -1, 6);
        pop_cmp("rEFFF_cs", o_rom); pop_cmp("rEFFF_wait", o_wait);

`ifdef Z80RC_TIMEOUT_EN
        // RDY never comes: timeout after 10 IO_WT clocks.
        push("to_wait", 11); push("to_err", 1); push("to_done", 1); push("to_after", 0);
        run_read(16'h0001, 1'b1, 1'b1, -1, 40);
        pop_cmp("to_wait", o_wait); pop_cmp("to_err", o_err);
        pop_cmp("to_done", o_done); pop_cmp("to_after", o_after);
`endif

        // Abort: RD rises during IO_WT, everything drops on the next clock.
        @(negedge clock);
        drive_read(16'h0001, 1'b1, 1'b1);
        bus.s100_rdy = 1'b0;
        repeat (3) @(negedge clock);
        push("abort_pre_pdbin", 1);
        pop_cmp("abort_pre_pdbin", int'(bus.s100_pdbin));
        drive_idle();
        @(negedge clock);
        push("abort_after", 1);
        pop_cmp("abort_after", pack_out());
        repeat (2) @(negedge clock);

        // Asynchronous reset during IO_WT, then a normal ROM read.
        drive_read(16'h0002, 1'b1, 1'b1);
        bus.s100_rdy = 1'b0;
        repeat (3) @(negedge clock);
        push("rst_pre_pdbin", 1);
        pop_cmp("rst_pre_pdbin", int'(bus.s100_pdbin));
        #2;
        reset_n = 1'b0;
        #1;
        push("rst_async", 1);
        pop_cmp("rst_async", pack_out());
        @(negedge clock);
        drive_idle();
        @(negedge clock);
        reset_n = 1'b1;
        push("post_rst_cs", 1); push("post_rst_wait", 1);
        run_read(16'hF123, 1'b0, 1'b1, -1, 20);
        pop_cmp("post_rst_cs", o_rom); pop_cmp("post_rst_wait", o_wait);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z80_read_ctrl.md
# z80_read_ctrl

Read-cycle controller for the Z80 CPU data-input path. Decodes each CPU memory/IO read, drives the one-hot device selects (`rom_cs`, `inport_cs`) that steer the CPU data-input multiplexer, and inserts wait states. It runs the S-100 input-port handshake (`sINP`/`pDBIN`/`RDY`) and guarantees the mux selects are never active together.

## Interface
Parameters:
- `ROM_BASE`, default 16'hF000: ROM base address; the low `ROM_AW` bits are ignored.
- `ROM_AW`, default 12: ROM address width; the window is 2^ROM_AW bytes.
- `ROM_WAITS`, default 1: wait cycles added to each ROM read, range 0..7.
- `PORT_LO`, default 8'h00: lowest IO port routed to the S-100 bus.
- `PORT_HI`, default 8'hFF: highest IO port routed to the S-100 bus (inclusive).
- `RDY_TIMEOUT`, default 255: maximum clocks to wait for `s100_rdy`. Used only with `Z80RC_TIMEOUT_EN`.

Ports:
- `clock`  in  1  system clock; all CPU inputs are synchronous to it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  16  CPU address bus.
- `cpu_mreq_n`  in  1  memory request.
- `cpu_iorq_n`  in  1  IO request.
- `cpu_rd_n`  in  1  read strobe.
- `cpu_m1_n`  in  1  opcode fetch. M1 with IORQ (interrupt acknowledge) is not a port read.
- `s100_rdy`  in  1  S-100 ready; 1 = data valid.
- `rom_cs`  out  1  ROM select to the data-input mux.
- `inport_cs`  out  1  S-100 input-port select to the data-input mux.
- `cpu_wait_n`  out  1  CPU WAIT line, active low.
- `s100_sinp`  out  1  S-100 input-cycle status.
- `s100_pdbin`  out  1  S-100 data-bus-in strobe.
- `bus_err`  out  1  one-clock pulse on an RDY timeout.

## Operation
- All outputs are registered. Reset values:
  - `rom_cs` = 0, `inport_cs` = 0, `s100_sinp` = 0, `s100_pdbin` = 0, `bus_err` = 0.
  - `cpu_wait_n` = 1.
  - State = IDLE.
- FSM states: IDLE, ROM_WT, ROM_RD, IO_SETUP, IO_WT, IO_RD, END.
- IDLE: a read is detected when `cpu_rd_n` = 0 with exactly one of `cpu_mreq_n`/`cpu_iorq_n` low.
  - Memory read with `cpu_addr[15:ROM_AW]` == `ROM_BASE[15:ROM_AW]`: go to ROM_WT if `ROM_WAITS` > 0, else ROM_RD.
  - IO read with `PORT_LO` ≤ `cpu_addr[7:0]` ≤ `PORT_HI` and `cpu_m1_n` = 1: go to IO_SETUP.
  - Any other read: no select is asserted and the mux default applies; stay in IDLE.
- ROM_WT: `rom_cs` = 1 and `cpu_wait_n` = 0; count `ROM_WAITS` clocks, then go to ROM_RD.
- ROM_RD: `rom_cs` = 1 and `cpu_wait_n` = 1; stay until `cpu_rd_n` rises, then go to END.
- IO_SETUP: `inport_cs` = 1, `s100_sinp` = 1, `cpu_wait_n` = 0; lasts one clock, then go to IO_WT.
- IO_WT: adds `s100_pdbin` = 1. When `s100_rdy` is sampled 1, go to IO_RD.
- IO_RD: `inport_cs`, `s100_sinp` and `s100_pdbin` held at 1, `cpu_wait_n` = 1; stay until `cpu_rd_n` rises, then go to END.
- END: all selects and strobes are 0; lasts one clock, then go to IDLE. This forces one dead clock between successive cycles.
- Invariants, asserted in the bench:
  - `rom_cs & inport_cs` is never 1.
  - `s100_pdbin` = 1 only while `inport_cs` = 1.
- Abort: if `cpu_rd_n` rises in any state other than IDLE or END, go to END on the next clock. This covers the CPU core being reset.
- Reset asserted mid-cycle: all outputs return to their reset values immediately (asynchronous reset). `cpu_wait_n` is released.

## Timing
- Decode latency: selects assert on the clock edge after the read is detected.
- ROM read: `cpu_wait_n` is low for exactly `ROM_WAITS` clocks.
- IO read:
  - `cpu_wait_n` is low for 1 + N clocks, where N is the number of IO_WT clocks until `s100_rdy` is sampled 1; the minimum is 2 clocks.
  - `s100_rdy` already 1 on entry to IO_WT still costs one IO_WT clock.
- Selects fall on the clock after `cpu_rd_n` rises.

## Configuration
- `Z80RC_TIMEOUT_EN` defined:
  - An 8-bit counter runs in IO_WT.
  - Reaching `RDY_TIMEOUT` forces a move to IO_RD, pulses `bus_err` for one clock and releases WAIT. The mux then returns whatever is on the S-100 bus.
- Not defined: IO_WT waits indefinitely for `s100_rdy`, and `bus_err` is tied to 0.

## Structure
- Package `z80_bus_pkg`:
  - State enum encoding.
  - `ROM_WAITS_MAX` = 7.
  - Device-select codes shared with the data-input mux.
- Sub-module `z80rc_addr_dec`: combinational ROM-window and port-range decode.
- The FSM, wait counter and timeout counter stay in the top module.

## Test plan
- ROM read at 16'hF123 with `ROM_WAITS` = 1 → `rom_cs` = 1, `cpu_wait_n` low for 1 clock; `rom_cs` drops 1 clock after `cpu_rd_n` rises.
- IO read of port 8'h01 with `s100_rdy` delayed 5 clocks → `s100_sinp`, then `s100_pdbin`; `cpu_wait_n` low for 6 clocks; `inport_cs` = 1 throughout.
- Memory read at 16'h0100 → both selects stay 0 and `cpu_wait_n` stays 1.
- Interrupt acknowledge (`cpu_m1_n` = 0 with `cpu_iorq_n` = 0) → no `inport_cs` and no `s100_sinp`.
- With `Z80RC_TIMEOUT_EN`, `RDY_TIMEOUT` = 10 and `s100_rdy` held at 0 → one `bus_err` pulse after 10 IO_WT clocks, then `cpu_wait_n` = 1.
- `reset_n` pulsed low during IO_WT → all outputs return to reset values immediately; the next read decodes normally.
